// File: rtl/xor_gate.sv
// Bitwise XOR primitive (a ^ b) built from AND/OR/NOT terms, with a registered
// copy of the result, a reduction parity bit and a running XOR accumulator.
module xor_gate #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] out,
    output logic             par,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] xor_s;
    logic             par_s;
    logic [WIDTH-1:0] out_q_r;
    logic [WIDTH-1:0] acc_r;

    // Sum-of-products XOR per bit: (x & ~y) | (~x & y).
    function automatic logic [WIDTH-1:0] gate_xor(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = (x[i] & ~y[i]) | (~x[i] & y[i]);
        end
        return r;
    endfunction

    // Even-parity reduction across every bit of the vector.
    function automatic logic reduce_parity(input logic [WIDTH-1:0] v);
        logic p;
        p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            p = p ^ v[i];
        end
        return p;
    endfunction

    // Combinational XOR and parity; deliberately independent of clk and reset.
    always_comb begin
        xor_s = gate_xor(a, b);
        par_s = reduce_parity(xor_s);
    end

    // Output register: loads a ^ b when enabled, otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q_r <= {WIDTH{1'b0}};
        end else if (en) begin
            out_q_r <= xor_s;
        end else begin
            out_q_r <= out_q_r;
        end
    end

    // Accumulator: clear wins over accumulate, otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r <= {WIDTH{1'b0}};
        end else begin
            case ({acc_clr, acc_en})
                2'b10, 2'b11: acc_r <= {WIDTH{1'b0}};
                2'b01:        acc_r <= gate_xor(acc_r, xor_s);
                default:      acc_r <= acc_r;
            endcase
        end
    end

    assign out   = xor_s;
    assign par   = par_s;
    assign out_q = out_q_r;
    assign acc   = acc_r;

endmodule

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate: WIDTH=1 truth table plus WIDTH=8 register,
// accumulator and asynchronous-reset sequences checked through a scoreboard.
module tb_xor_gate;

    logic       clk;
    logic       reset;
    logic       a1, b1, en1, acc_en1, acc_clr1;
    logic       out1, par1, out_q1, acc1;
    logic [7:0] a8, b8, out8, out_q8, acc8;
    logic       en8, acc_en8, acc_clr8, par8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic a, b, e_out;
    } vec1_t;

    typedef struct {
        logic [7:0] a, b;
        logic       en, acc_en, acc_clr;
        logic [7:0] e_out;
        logic       e_par;
        logic [7:0] e_q, e_acc;
    } vec8_t;

    typedef struct {
        logic [7:0] q, acc;
    } sb_t;

    sb_t   sbq[$];
    vec1_t v1[4];
    vec8_t v8[10];

    xor_gate #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .a(a1), .b(b1), .en(en1), .acc_en(acc_en1),
        .acc_clr(acc_clr1), .out(out1), .par(par1), .out_q(out_q1), .acc(acc1)
    );

    xor_gate #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .en(en8), .acc_en(acc_en8),
        .acc_clr(acc_clr8), .out(out8), .par(par8), .out_q(out_q8), .acc(acc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        sb_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got q=%h acc=%h", name, out_q8, acc8);
        end else begin
            e = sbq.pop_front();
            chk({name, " out_q"}, 64'(out_q8), 64'(e.q));
            chk({name, " acc"}, 64'(acc8), 64'(e.acc));
        end
    endtask

    initial begin
        v1[0] = '{1'b0, 1'b0, 1'b0};
        v1[1] = '{1'b0, 1'b1, 1'b1};
        v1[2] = '{1'b1, 1'b0, 1'b1};
        v1[3] = '{1'b1, 1'b1, 1'b0};

        //        a      b      en    acc_en acc_clr out    par   q      acc
        v8[0] = '{8'hA5, 8'h0F, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 8'hAA, 8'h00};
        v8[1] = '{8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b0, 8'hAA, 8'h00};
        v8[2] = '{8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 8'hAA, 8'h01};
        v8[3] = '{8'h03, 8'h01, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 8'hAA, 8'h03};
        v8[4] = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 8'hAA, 8'h02};
        v8[5] = '{8'hF0, 8'h0F, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'hAA, 8'h00};
        v8[6] = '{8'h3C, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C, 8'h3C};
        v8[7] = '{8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C, 8'h00};
        v8[8] = '{8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C, 8'h3C};
        v8[9] = '{8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 8'hAA, 8'h3C};

        reset = 1'b1;
        a1 = 1'b0; b1 = 1'b0; en1 = 1'b0; acc_en1 = 1'b0; acc_clr1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; en8 = 1'b0; acc_en8 = 1'b0; acc_clr8 = 1'b0;
        #1;
        chk("reset out_q8", 64'(out_q8), 64'h0);
        chk("reset acc8", 64'(acc8), 64'h0);
        chk("reset out_q1", 64'(out_q1), 64'h0);

        // Truth table runs with reset held high: combinational path ignores it.
        for (int i = 0; i < 4; i++) begin
            a1 = v1[i].a;
            b1 = v1[i].b;
            #1;
            chk($sformatf("tt%0d out", i), 64'(out1), 64'(v1[i].e_out));
            chk($sformatf("tt%0d par", i), 64'(par1), 64'(v1[i].e_out));
        end

        @(negedge clk);
        reset = 1'b0;

        // WIDTH=1 register load of a^b = 1.
        a1 = 1'b1; b1 = 1'b0; en1 = 1'b1; acc_en1 = 1'b1;
        @(posedge clk);
        #1;
        chk("w1 out_q", 64'(out_q1), 64'h1);
        chk("w1 acc", 64'(acc1), 64'h1);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a8 = v8[i].a; b8 = v8[i].b;
            en8 = v8[i].en; acc_en8 = v8[i].acc_en; acc_clr8 = v8[i].acc_clr;
            #1;
            chk($sformatf("v%0d out", i), 64'(out8), 64'(v8[i].e_out));
            chk($sformatf("v%0d par", i), 64'(par8), 64'(v8[i].e_par));
            sbq.push_back('{v8[i].e_q, v8[i].e_acc});
            @(posedge clk);
            #1;
            pop_check($sformatf("v%0d", i));
        end

        // Async reset between edges with out_q=AA, acc=3C.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'hA5; en8 = 1'b1; acc_en8 = 1'b1; acc_clr8 = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("rst out_q", 64'(out_q8), 64'h0);
        chk("rst acc", 64'(acc8), 64'h0);
        chk("rst out", 64'(out8), 64'hFF);
        sbq.push_back('{8'h00, 8'h00});
        @(posedge clk);
        #1;
        pop_check("rst hold");
        a8 = 8'h0F; b8 = 8'hF3;
        #1;
        chk("rst track", 64'(out8), 64'hFC);

        @(negedge clk);
        reset = 1'b0;
        a8 = 8'h12; b8 = 8'h34;
        sbq.push_back('{8'h26, 8'h26});
        @(posedge clk);
        #1;
        pop_check("post rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xor_gate.md
# xor_gate

Bitwise exclusive-OR primitive for the gate-level library, built up from the basic NAND/NOT/AND/OR gates. The core is a purely combinational `out = a ^ b` path with a 1-bit default width, matching the classic two-input XOR truth table. A clocked wrapper adds a registered copy of the result, a reduction parity bit and an XOR accumulator, so sequential blocks (ALU flags, checksum logic) can use it directly.

## Interface
- WIDTH, 1, bit width of `a`, `b`, `out`, `out_q`, `acc`; legal range 1..64.
- clk  input  1  rising-edge clock for all registers.
- reset  input  1  asynchronous, active-high; clears all registers.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- en  input  1  load enable for `out_q`.
- acc_en  input  1  accumulate enable: `acc <= acc ^ out`.
- acc_clr  input  1  synchronous accumulator clear.
- out  output  WIDTH  combinational `a ^ b`.
- par  output  1  combinational reduction XOR of `out`, i.e. XOR of all bits of `a` and `b`.
- out_q  output  WIDTH  registered `out`.
- acc  output  WIDTH  running XOR accumulator.

## Operation
- Combinational path:
  - Each bit is `out[i] = (a[i] & ~b[i]) | (~a[i] & b[i])`.
  - The logic uses no clock and no reset; `reset` has no effect on `out` or `par`.
  - When WIDTH=1, `par == out`.
- Output register `out_q`, on each rising `clk` with `reset` low:
  - `en=1`: `out_q <= a ^ b`.
  - `en=0`: `out_q` holds its value.
- Accumulator `acc`, on each rising `clk` with `reset` low:
  - `acc_clr=1`: `acc <= 0`. This overrides `acc_en`.
  - `acc_clr=0, acc_en=1`: `acc <= acc ^ (a ^ b)`.
  - Otherwise `acc` holds.
- Arithmetic:
  - XOR has no carry and no overflow.
  - All widths are exactly WIDTH.
  - The accumulator wraps naturally: XOR-ing the same value twice returns `acc` to its prior value.
- `out_q` and `acc` are independent. `en` and `acc_en` may be asserted in the same cycle; both updates then occur from the same pre-edge `a`, `b`.
- Unknown or X inputs propagate per standard Verilog XOR semantics. No X-masking is performed.

## Timing
- Reset values: `out_q = 0`, `acc = 0`.
  - `out` and `par` have no reset value; they follow `a`, `b` continuously.
- Asserting `reset` clears `out_q` and `acc` immediately, with no clock edge required. This applies at any time, including mid-accumulation.
- While `reset` is high, clock edges are ignored.
- On deassertion, the first rising `clk` with `reset` low performs a normal update.
- Latency:
  - `out` and `par`: 0 cycles, combinational. They must be stable within 1 time unit of an input change in a zero-delay simulation.
  - `out_q`: 1 cycle after the capturing edge.
  - `acc`: 1 cycle per accumulate step.
- No handshake. Inputs are sampled at the rising edge and must meet setup/hold relative to `clk`.

## Test plan
- WIDTH=1 truth table, each row checked 1 time unit after the input change:
  - a=0,b=0 -> out=0
  - a=0,b=1 -> out=1
  - a=1,b=0 -> out=1
  - a=1,b=1 -> out=0
  - `par` equals `out` in every row.
- Register path, WIDTH=8:
  - a=8'hA5, b=8'h0F, en=1 over one edge -> out=8'hAA immediately, out_q=8'hAA after the edge, par=0.
  - Then en=0 and a=8'hFF -> out_q stays 8'hAA.
- Accumulator, WIDTH=8:
  - After reset, acc_en=1 for three edges with a^b = 8'h01, 8'h02, 8'h01 -> acc reads 8'h01, 8'h03, 8'h02.
- Clear priority: acc=8'h02, acc_clr=1 and acc_en=1 together with a^b=8'hFF -> acc=8'h00 after the edge.
- Async reset mid-operation:
  - With out_q=8'hAA and acc=8'h3C, pulse reset between clock edges -> both read 0 before the next edge.
  - `out` keeps tracking a^b throughout the pulse.
  - After release, the next edge with en=1 loads normally.
